// File: rtl/mips_boot_loader_pkg.sv
// Shared types and default widths for the MIPS boot loader and imem.
package mips_boot_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int HOLD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/mips_boot_loader_if.sv
// Instruction-word stream into the boot loader (valid/ready).
interface mips_boot_loader_if #(
  parameter int DATA_W = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/mips_boot_loader.sv
// Streams an image into imem from address 0, then releases the core.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mips_boot_loader_if.slave s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum,
  output logic              overflow_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_IDX =
    {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] cs_q;
  logic              accept;

  assign s.s_ready = reset & (state_q == LOAD);
  assign accept    = s.s_valid & s.s_ready;

  // Counter runs HOLD_CYCLES..0, so the core sees
  // HOLD_CYCLES+1 held cycles after the last accept.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          unique case (1'b1)
            s.s_last: begin
              state_d = HOLD;
              hold_d  = HW'(HOLD_CYCLES);
            end
            (cnt_q == LAST_IDX): state_d = ERROR;
            default: ;
          endcase
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      RUN:   ;
      ERROR: ;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      we_q    <= accept;
      if (accept) begin
        addr_q  <= cnt_q[ADDR_W-1:0];
        wdata_q <= s.s_data;
        cs_q    <= cs_q ^ s.s_data;
        if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign word_count   = cnt_q;
  assign checksum     = cs_q;
  assign cpu_reset    = (state_q != RUN);
  assign load_done    = (state_q == RUN);
  assign overflow_err = (state_q == ERROR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader (default and ADDR_W=2 builds).
module tb_mips_boot_loader;

  localparam logic [31:0] SENT = 32'h0BAD0BAD;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        e_rdy;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_rst;
    logic        e_done;
    logic [8:0]  e_cnt;
    logic [31:0] e_cs;
  } vec_t;

  logic clk;
  logic reset;
  logic mem_clr;

  mips_boot_loader_if #(.DATA_W(32)) s8 ();
  mips_boot_loader_if #(.DATA_W(32)) s2 ();

  logic        we8, rst8, done8, ovf8;
  logic [7:0]  addr8;
  logic [31:0] wd8, cs8;
  logic [8:0]  cnt8;

  logic        we2, rst2, done2, ovf2;
  logic [1:0]  addr2;
  logic [31:0] wd2, cs2;
  logic [2:0]  cnt2;

  mips_boot_loader u8 (
    .clk          (clk),
    .reset        (reset),
    .s            (s8),
    .imem_we      (we8),
    .imem_addr    (addr8),
    .imem_wdata   (wd8),
    .cpu_reset    (rst8),
    .load_done    (done8),
    .word_count   (cnt8),
    .checksum     (cs8),
    .overflow_err (ovf8)
  );

  mips_boot_loader #(.ADDR_W(2)) u2 (
    .clk          (clk),
    .reset        (reset),
    .s            (s2),
    .imem_we      (we2),
    .imem_addr    (addr2),
    .imem_wdata   (wd2),
    .cpu_reset    (rst2),
    .load_done    (done2),
    .word_count   (cnt2),
    .checksum     (cs2),
    .overflow_err (ovf2)
  );

  logic [31:0] mem8 [256];
  logic [31:0] mem2 [4];
  int          wr8;
  int          wr2;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem8[i] <= SENT;
      for (int i = 0; i < 4; i++) mem2[i] <= SENT;
      wr8 <= 0;
      wr2 <= 0;
    end else begin
      if (we8) begin
        mem8[addr8] <= wd8;
        wr8 <= wr8 + 1;
      end
      if (we2) begin
        mem2[addr2] <= wd2;
        wr2 <= wr2 + 1;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] img [4];
  vec_t        tv [7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v,
                      input logic [31:0] d,
                      input logic l);
    s8.s_valid = v;
    s8.s_data  = d;
    s8.s_last  = l;
    tick();
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    s8.s_valid = 1'b0;
    s2.s_valid = 1'b0;
    mem_clr    = 1'b1;
    tick();
    mem_clr = 1'b0;
    chk("rst_ready", s8.s_ready, 0);
    chk("rst_we", we8, 0);
    chk("rst_addr", addr8, 0);
    chk("rst_wdata", wd8, 0);
    chk("rst_cpu_reset", rst8, 1);
    chk("rst_done", done8, 0);
    chk("rst_count", cnt8, 0);
    chk("rst_cs", cs8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_ovf2", ovf2, 0);
    reset = 1'b1;
    #1;
    chk("rst_ready_after", s8.s_ready, 1);
  endtask

  task automatic check_image(input string nm);
    for (int i = 0; i < 4; i++)
      chk({nm, "_mem"}, mem8[i], img[i]);
    chk({nm, "_mem4"}, mem8[4], SENT);
    chk({nm, "_cs"}, cs8, 32'hAD025026);
    chk({nm, "_cnt"}, cnt8, 9'd4);
  endtask

  task automatic check_release(input string nm);
    step(1'b0, 32'h0, 1'b0);
    chk({nm, "_rst_e1"}, rst8, 1);
    step(1'b0, 32'h0, 1'b0);
    chk({nm, "_rst_e2"}, rst8, 1);
    chk({nm, "_done_e2"}, done8, 0);
    step(1'b0, 32'h0, 1'b0);
    chk({nm, "_rst_e3"}, rst8, 0);
    chk({nm, "_done_e3"}, done8, 1);
  endtask

  initial begin
    logic [31:0] exp_cs2;
    #200000;
    exp_cs2 = '0;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_cs2;
    reset      = 1'b0;
    mem_clr    = 1'b1;
    s8.s_valid = 1'b0;
    s8.s_data  = '0;
    s8.s_last  = 1'b0;
    s2.s_valid = 1'b0;
    s2.s_data  = '0;
    s2.s_last  = 1'b0;

    img[0] = 32'h20080005;
    img[1] = 32'h20090003;
    img[2] = 32'h01095020;
    img[3] = 32'hAC0A0000;

    tv[0] = '{1'b1, 32'h20080005, 1'b0, 1'b1, 1'b1,
              8'd0, 32'h20080005, 1'b1, 1'b0,
              9'd1, 32'h20080005};
    tv[1] = '{1'b1, 32'h20090003, 1'b0, 1'b1, 1'b1,
              8'd1, 32'h20090003, 1'b1, 1'b0,
              9'd2, 32'h00010006};
    tv[2] = '{1'b1, 32'h01095020, 1'b0, 1'b1, 1'b1,
              8'd2, 32'h01095020, 1'b1, 1'b0,
              9'd3, 32'h01085026};
    tv[3] = '{1'b1, 32'hAC0A0000, 1'b1, 1'b0, 1'b1,
              8'd3, 32'hAC0A0000, 1'b1, 1'b0,
              9'd4, 32'hAD025026};
    tv[4] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0,
              8'd3, 32'hAC0A0000, 1'b1, 1'b0,
              9'd4, 32'hAD025026};
    tv[5] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0,
              8'd3, 32'hAC0A0000, 1'b1, 1'b0,
              9'd4, 32'hAD025026};
    tv[6] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0,
              8'd3, 32'hAC0A0000, 1'b0, 1'b1,
              9'd4, 32'hAD025026};

    // 1: back-to-back load, release 3 edges later
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tv[i].v, tv[i].d, tv[i].l);
      chk($sformatf("t1_ready%0d", i), s8.s_ready, tv[i].e_rdy);
      chk($sformatf("t1_we%0d", i), we8, tv[i].e_we);
      chk($sformatf("t1_addr%0d", i), addr8, tv[i].e_addr);
      chk($sformatf("t1_wd%0d", i), wd8, tv[i].e_wd);
      chk($sformatf("t1_rst%0d", i), rst8, tv[i].e_rst);
      chk($sformatf("t1_done%0d", i), done8, tv[i].e_done);
      chk($sformatf("t1_cnt%0d", i), cnt8, tv[i].e_cnt);
      chk($sformatf("t1_cs%0d", i), cs8, tv[i].e_cs);
    end
    check_image("t1");

    // 5: traffic after RUN is ignored
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hDEADBEEF, i[0]);
      chk("t5_ready", s8.s_ready, 0);
      chk("t5_we", we8, 0);
      chk("t5_rst", rst8, 0);
    end
    chk("t5_cs", cs8, 32'hAD025026);
    chk("t5_cnt", cnt8, 9'd4);
    chk("t5_wr", wr8, 4);

    // 2: bubbles carrying junk data and s_last
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, img[i], i == 3);
      chk("t2_we_acc", we8, 1);
      chk("t2_addr", addr8, i);
      if (i < 3) begin
        step(1'b0, 32'hFFFFFFFF, 1'b1);
        chk("t2_we_bub", we8, 0);
        chk("t2_cnt_bub", cnt8, i + 1);
      end
    end
    check_release("t2");
    check_image("t2");
    chk("t2_wr", wr8, 4);

    // 4: reset mid-image, then full reload
    do_reset();
    step(1'b1, img[0], 1'b0);
    step(1'b1, img[1], 1'b0);
    chk("t4_cnt_mid", cnt8, 9'd2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, img[i], i == 3);
      chk("t4_addr", addr8, i);
    end
    check_release("t4");
    check_image("t4");

    // 6: single-word image
    do_reset();
    step(1'b1, img[0], 1'b1);
    chk("t6_cnt", cnt8, 9'd1);
    chk("t6_ready", s8.s_ready, 0);
    chk("t6_done_e0", done8, 0);
    check_release("t6");

    // 3: overflow on the 4-word build
    do_reset();
    exp_cs2 = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready", s2.s_ready, i < 4);
      s2.s_valid = 1'b1;
      s2.s_data  = 32'h11111111 * (i + 1);
      s2.s_last  = 1'b0;
      if (i < 4) exp_cs2 = exp_cs2 ^ s2.s_data;
      tick();
    end
    s2.s_valid = 1'b0;
    tick();
    chk("t3_ovf", ovf2, 1);
    chk("t3_rst", rst2, 1);
    chk("t3_done", done2, 0);
    chk("t3_ready_end", s2.s_ready, 0);
    chk("t3_cnt", cnt2, 3'd4);
    chk("t3_cs", cs2, exp_cs2);
    chk("t3_wr", wr2, 4);
    for (int i = 0; i < 4; i++)
      chk("t3_mem", mem2[i], 32'h11111111 * (i + 1));
    do_reset();
    chk("t3_ovf_clr", ovf2, 0);
    chk("t3_cnt_clr", cnt2, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
